// File: rtl/clock_route_path_ctrl.sv
// Break-before-make sequencer for the two clock-route path gate enables.
// Optional error flag/clear ports are added when CLOCK_ROUTE_PATH_CTRL_ERR_EN is defined.
module clock_route_path_ctrl #(
   parameter int unsigned DEAD_CYCLES = 4,
   parameter int unsigned CNT_W       = 4,
   parameter logic [1:0]  RESET_SEL   = 2'd0
) (
   input  logic       clock,
   input  logic       async_reset,
   input  logic       sel_valid,
   input  logic [1:0] sel_code,
`ifdef CLOCK_ROUTE_PATH_CTRL_ERR_EN
   input  logic       err_clr,
   output logic       err_flag,
`endif
   output logic       sel_ready,
   output logic       sel_done,
   output logic       control_path_enable0,
   output logic       control_path_enable1,
   output logic [1:0] active_path,
   output logic       busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_ENABLE = 2'd2
   } state_t;

   // One-hot enable pattern {enable1, enable0} for a selection code; off and 3 map to none.
   function automatic logic [1:0] path_decode(input logic [1:0] code);
      logic [1:0] en;
      case (code)
         2'd1:    en = 2'b01;
         2'd2:    en = 2'b10;
         default: en = 2'b00;
      endcase
      return en;
   endfunction

   generate
      if (DEAD_CYCLES < 1) begin : g_dead_chk
         $error("clock_route_path_ctrl: DEAD_CYCLES must be at least 1");
      end
      if ((64'd1 << CNT_W) <= 64'(DEAD_CYCLES)) begin : g_cnt_chk
         $error("clock_route_path_ctrl: CNT_W too narrow for DEAD_CYCLES");
      end
      if (RESET_SEL == 2'd3) begin : g_rst_chk
         $error("clock_route_path_ctrl: RESET_SEL must not be 3");
      end
   endgenerate

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEAD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [1:0]       RST_EN   = path_decode(RESET_SEL);

   state_t           state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [1:0]       target_r, target_s;
   logic [1:0]       en_r, en_s;
   logic [1:0]       active_r, active_s;
   logic             done_r, done_s;
   logic             ready_r;
   logic             busy_r;
   logic             err_set_s;

   // Next-state and next-output logic of the switch sequencer.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      target_s  = target_r;
      en_s      = en_r;
      active_s  = active_r;
      done_s    = 1'b0;
      err_set_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (sel_valid) begin
               if (sel_code == 2'd3) begin
                  done_s    = 1'b1;
                  err_set_s = 1'b1;
               end else if (sel_code == active_r) begin
                  done_s = 1'b1;
               end else begin
                  // Drop the live enable first; the new one is raised only after the dead time.
                  target_s = sel_code;
                  en_s     = 2'b00;
                  cnt_s    = CNT_LOAD;
                  state_s  = (DEAD_CYCLES > 1) ? ST_DRAIN : ST_ENABLE;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            cnt_s = cnt_r - CNT_ONE;
            if (cnt_r <= CNT_ONE) begin
               state_s = ST_ENABLE;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         ST_ENABLE: begin
            en_s     = path_decode(target_r);
            active_s = target_r;
            done_s   = 1'b1;
            state_s  = ST_IDLE;
         end
         default: begin
            en_s    = 2'b00;
            cnt_s   = '0;
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset restores the RESET_SEL selection directly.
   always_ff @(posedge clock or posedge async_reset) begin
      if (async_reset) begin
         state_r  <= ST_IDLE;
         cnt_r    <= '0;
         target_r <= RESET_SEL;
         en_r     <= RST_EN;
         active_r <= RESET_SEL;
         done_r   <= 1'b0;
         ready_r  <= 1'b1;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         target_r <= target_s;
         en_r     <= en_s;
         active_r <= active_s;
         done_r   <= done_s;
         ready_r  <= (state_s == ST_IDLE);
         busy_r   <= (state_s != ST_IDLE);
      end
   end

`ifdef CLOCK_ROUTE_PATH_CTRL_ERR_EN
   logic err_r;

   // Sticky illegal-code flag; a set in the same cycle as a clear takes priority.
   always_ff @(posedge clock or posedge async_reset) begin
      if (async_reset) begin
         err_r <= 1'b0;
      end else if (err_set_s) begin
         err_r <= 1'b1;
      end else if (err_clr) begin
         err_r <= 1'b0;
      end else begin
         err_r <= err_r;
      end
   end

   assign err_flag = err_r;
`endif

   assign sel_ready            = ready_r;
   assign sel_done             = done_r;
   assign control_path_enable0 = en_r[0];
   assign control_path_enable1 = en_r[1];
   assign active_path          = active_r;
   assign busy                 = busy_r;

endmodule

// File: tb/tb_clock_route_path_ctrl.sv
// Directed scoreboard bench for clock_route_path_ctrl (two instances: RESET_SEL=0 and RESET_SEL=2).
// Honors CLOCK_ROUTE_PATH_CTRL_ERR_EN for the error-flag checks.
module tb_clock_route_path_ctrl;

   localparam int DEAD = 4;

   logic       clock = 1'b0;
   logic       rst, valid, ready, done, en0, en1, busy;
   logic [1:0] code, active;
   logic       rst2, valid2, ready2, done2, en20, en21, busy2;
   logic [1:0] code2, active2;
`ifdef CLOCK_ROUTE_PATH_CTRL_ERR_EN
   logic       err_clr, err_flag, err_clr2, err_flag2;
`endif

   int tests  = 0;
   int failed = 0;

   typedef struct {
      logic [1:0] active;
      logic [1:0] en;
      int         lat;
   } exp_t;

   exp_t       sb[$];
   logic [1:0] model_active;

   always #5 clock = ~clock;

   clock_route_path_ctrl #(.DEAD_CYCLES(DEAD), .CNT_W(4), .RESET_SEL(2'd0)) dut (
      .clock(clock), .async_reset(rst), .sel_valid(valid), .sel_code(code),
`ifdef CLOCK_ROUTE_PATH_CTRL_ERR_EN
      .err_clr(err_clr), .err_flag(err_flag),
`endif
      .sel_ready(ready), .sel_done(done),
      .control_path_enable0(en0), .control_path_enable1(en1),
      .active_path(active), .busy(busy)
   );

   clock_route_path_ctrl #(.DEAD_CYCLES(DEAD), .CNT_W(4), .RESET_SEL(2'd2)) dut2 (
      .clock(clock), .async_reset(rst2), .sel_valid(valid2), .sel_code(code2),
`ifdef CLOCK_ROUTE_PATH_CTRL_ERR_EN
      .err_clr(err_clr2), .err_flag(err_flag2),
`endif
      .sel_ready(ready2), .sel_done(done2),
      .control_path_enable0(en20), .control_path_enable1(en21),
      .active_path(active2), .busy(busy2)
   );

   function automatic logic [1:0] exp_en(input logic [1:0] sel);
      if (sel == 2'd1) return 2'b01;
      else if (sel == 2'd2) return 2'b10;
      else return 2'b00;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives one request on dut, pushes the model's expectation and pops it when sel_done appears.
   task automatic request(input logic [1:0] c, input bit hold);
      exp_t e, got;
      bit   seen;
      if (c == 2'd3 || c == model_active) begin
         e.lat    = 1;
         e.active = model_active;
      end else begin
         e.lat    = DEAD + 1;
         e.active = c;
      end
      e.en = exp_en(e.active);
      model_active = e.active;
      sb.push_back(e);
      valid = 1'b1;
      code  = c;
      seen  = 1'b0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         @(negedge clock);
         chk("onehot", {31'd0, en0 & en1}, 32'd0);
         if (done) begin
            seen  = 1'b1;
            valid = 1'b0;
            got   = sb.pop_front();
            chk("latency", 32'(k), 32'(got.lat));
            chk("active_path", {30'd0, active}, {30'd0, got.active});
            chk("enables", {30'd0, en1, en0}, {30'd0, got.en});
            chk("ready_busy_done", {30'd0, ready, busy}, 32'd2);
`ifdef CLOCK_ROUTE_PATH_CTRL_ERR_EN
            if (c == 2'd3) chk("err_set", {31'd0, err_flag}, 32'd1);
`endif
         end else begin
            if (hold) code = 2'($urandom_range(0, 3));
            else valid = 1'b0;
            chk("ready_busy_drain", {30'd0, ready, busy}, 32'd1);
            chk("enables_drain", {30'd0, en1, en0}, 32'd0);
         end
      end
      chk("timeout", {31'd0, seen}, 32'd1);
   endtask

   initial begin
      bit seen2;
      rst = 1'b1; rst2 = 1'b1;
      valid = 1'b0; code = 2'd0; valid2 = 1'b0; code2 = 2'd0;
`ifdef CLOCK_ROUTE_PATH_CTRL_ERR_EN
      err_clr = 1'b0; err_clr2 = 1'b0;
`endif
      model_active = 2'd0;
      repeat (2) @(negedge clock);
      chk("rst_enables", {30'd0, en1, en0}, 32'd0);
      chk("rst_active", {30'd0, active}, 32'd0);
      chk("rst_flags", {29'd0, ready, busy, done}, 32'd4);
      chk("rst2_enables", {30'd0, en21, en20}, 32'd2);
      rst = 1'b0; rst2 = 1'b0;
      @(negedge clock);
      chk("post_rst_flags", {29'd0, ready, busy, done}, 32'd4);
      chk("post_rst2_active", {30'd0, active2}, 32'd2);
`ifdef CLOCK_ROUTE_PATH_CTRL_ERR_EN
      chk("rst_err", {31'd0, err_flag}, 32'd0);
`endif

      // off->path0, same path, path0->path1, illegal, then held-valid scrambled switches
      request(2'd1, 1'b0);
      request(2'd1, 1'b0);
      request(2'd2, 1'b0);
      request(2'd3, 1'b0);
      request(2'd0, 1'b1);
      request(2'd2, 1'b1);
      request(2'd1, 1'b0);
      @(negedge clock);
      chk("done_pulse", {31'd0, done}, 32'd0);
      chk("idle_en", {30'd0, en1, en0}, 32'd1);

`ifdef CLOCK_ROUTE_PATH_CTRL_ERR_EN
      repeat (2) @(negedge clock);
      chk("err_held", {31'd0, err_flag}, 32'd1);
      err_clr = 1'b1;
      @(negedge clock);
      err_clr = 1'b0;
      chk("err_cleared", {31'd0, err_flag}, 32'd0);
      err_clr = 1'b1;
      request(2'd3, 1'b0);
      @(negedge clock);
      err_clr = 1'b0;
      chk("err_clr_after_set", {31'd0, err_flag}, 32'd0);
`else
      request(2'd3, 1'b0);
`endif

      // Reset pulsed two cycles into a path1->path0 switch on the RESET_SEL=2 instance
      valid2 = 1'b1; code2 = 2'd1;
      @(negedge clock);
      valid2 = 1'b0;
      chk("rst2_drain_en", {30'd0, en21, en20}, 32'd0);
      chk("rst2_drain_busy", {31'd0, busy2}, 32'd1);
      @(negedge clock);
      rst2 = 1'b1;
      #1;
      chk("rst2_mid_en", {30'd0, en21, en20}, 32'd2);
      chk("rst2_mid_flags", {29'd0, ready2, busy2, done2}, 32'd4);
      chk("rst2_mid_active", {30'd0, active2}, 32'd2);
      @(negedge clock);
      rst2 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         chk("rst2_no_done", {30'd0, done2, en21 & en20}, 32'd0);
      end
      valid2 = 1'b1; code2 = 2'd0;
      seen2 = 1'b0;
      for (int k = 1; k <= 40 && !seen2; k++) begin
         @(negedge clock);
         valid2 = 1'b0;
         if (done2) begin
            seen2 = 1'b1;
            chk("rst2_latency", 32'(k), 32'(DEAD + 1));
            chk("rst2_off", {28'd0, en21, en20, active2}, 32'd0);
         end
      end
      chk("rst2_timeout", {31'd0, seen2}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
